// File: rtl/universal_shift_pkg.sv
// Shared constants for the universal shift register: default width and mode encodings.
package universal_shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/universal_shift_next.sv
// Combinational next-state mux for the universal shift register.
// Ports:
//   s       mode select (hold / shift right / shift left / load)
//   q       current register contents
//   din     parallel load data, used only in load mode
//   sin     serial input bit, enters the vacated end on a shift
//   next_c  value the register takes on the next rising edge
module universal_shift_next
    import universal_shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] next_c
);

    // Shifted-out bits are dropped; nothing wraps around.
    always_comb begin
        next_c = q;
        case (s)
            MODE_HOLD: next_c = q;
            MODE_SHR:  next_c = {sin, q[WIDTH-1:1]};
            MODE_SHL:  next_c = {q[WIDTH-2:0], sin};
            MODE_LOAD: next_c = din;
            default:   next_c = q;
        endcase
    end

endmodule

// File: rtl/universal_shift.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or parallel
// load, selected each clock by a 2-bit mode.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears q
//   s    mode select
//   din  parallel load data
//   sin  serial input bit for both shift directions
//   q    registered register contents
module universal_shift
    import universal_shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next_q;

    universal_shift_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .s      (s),
        .q      (q),
        .din    (din),
        .sin    (sin),
        .next_c (next_q)
    );

    // State register; reset discards any in-progress shift contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= next_q;
        end
    end

endmodule

// File: tb/tb_universal_shift.sv
module tb_universal_shift;
    import universal_shift_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] s;
    logic       sin;
    logic [3:0] din4;
    logic [7:0] din8;
    logic [3:0] q4;
    logic [7:0] q8;

    int passed = 0;
    int total  = 0;

    // Reference values, maintained from the mode rules with plain arithmetic.
    int m4 = 0;
    int m8 = 0;

    universal_shift #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .din (din4),
        .sin (sin),
        .q   (q4)
    );

    universal_shift #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .din (din8),
        .sin (sin),
        .q   (q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_step(int cur, int w, logic [1:0] mode, int d, logic sn);
        int mask;
        int sbit;
        mask = (1 << w) - 1;
        sbit = sn ? 1 : 0;
        case (mode)
            2'b00:   return cur;
            2'b01:   return (cur / 2) + sbit * (1 << (w - 1));
            2'b10:   return ((cur * 2) + sbit) & mask;
            default: return d & mask;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 = 0;
            m8 = 0;
        end else begin
            m4 = model_step(m4, 4, s, int'(din4), sin);
            m8 = model_step(m8, 8, s, int'(din8), sin);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        check("model_q4", int'(q4), m4);
        check("model_q8", int'(q8), m8);
    end

    task automatic step(input logic [1:0] mode, input logic [3:0] d4,
                        input logic [7:0] d8, input logic sn);
        @(negedge clk);
        s    = mode;
        din4 = d4;
        din8 = d8;
        sin  = sn;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with load mode and all-ones data: q must stay zero.
        rst  = 1'b1;
        s    = MODE_LOAD;
        din4 = 4'hF;
        din8 = 8'hFF;
        sin  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hold_q4", int'(q4), 0);
        check("reset_hold_q8", int'(q8), 0);

        rst  = 1'b0;
        s    = MODE_HOLD;
        din4 = 4'h0;
        din8 = 8'h00;
        sin  = 1'b0;
        @(posedge clk);
        #2;
        check("first_edge_q4", int'(q4), 0);

        step(MODE_LOAD, 4'b1011, 8'h3C, 1'b0);
        check("load_1011", int'(q4), 'b1011);
        check("load_3c", int'(q8), 'h3C);

        step(MODE_SHR, 4'b0000, 8'hFF, 1'b1);
        check("shr_sin1", int'(q4), 'b1101);
        check("shr_sin1_w8", int'(q8), 'h9E);

        step(MODE_SHR, 4'b1111, 8'h00, 1'b0);
        check("shr_sin0", int'(q4), 'b0110);

        step(MODE_SHL, 4'b0000, 8'hAA, 1'b1);
        check("shl_sin1", int'(q4), 'b1101);
        check("shl_sin1_w8", int'(q8), 'h9F);

        step(MODE_HOLD, 4'b0101, 8'h33, 1'b1);
        check("hold_1", int'(q4), 'b1101);
        step(MODE_HOLD, 4'b1010, 8'hCC, 1'b0);
        check("hold_2", int'(q4), 'b1101);
        step(MODE_HOLD, 4'b0110, 8'h5A, 1'b1);
        check("hold_3", int'(q4), 'b1101);

        // Asynchronous reset pulsed between clock edges.
        step(MODE_LOAD, 4'b1111, 8'hF0, 1'b0);
        check("load_1111", int'(q4), 'b1111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_q4", int'(q4), 0);
        check("async_rst_q8", int'(q8), 0);
        #1;
        rst = 1'b0;
        s   = MODE_SHL;
        sin = 1'b1;
        @(posedge clk);
        #2;
        check("after_rst_shl", int'(q4), 'b0001);

        // Shifted-out bits are lost, never wrapped.
        step(MODE_SHL, 4'b0000, 8'h00, 1'b0);
        step(MODE_SHL, 4'b0000, 8'h00, 1'b0);
        step(MODE_SHL, 4'b0000, 8'h00, 1'b0);
        check("shl_to_msb", int'(q4), 'b1000);
        step(MODE_SHL, 4'b0000, 8'h00, 1'b0);
        check("shl_no_wrap", int'(q4), 'b0000);

        // 8-bit width.
        step(MODE_LOAD, 4'b0000, 8'hA5, 1'b0);
        check("w8_load_a5", int'(q8), 'hA5);
        step(MODE_SHR, 4'b0000, 8'h00, 1'b0);
        check("w8_shr_52", int'(q8), 'h52);
        step(MODE_SHR, 4'b0000, 8'h00, 1'b1);
        check("w8_shr_a9", int'(q8), 'hA9);

        // Short directed stream exercised only against the model.
        step(MODE_SHL, 4'b1001, 8'h81, 1'b1);
        step(MODE_SHR, 4'b0110, 8'h7E, 1'b0);
        step(MODE_LOAD, 4'b0110, 8'h7E, 1'b1);
        step(MODE_SHL, 4'b0000, 8'h00, 1'b0);
        step(MODE_HOLD, 4'b1111, 8'hFF, 1'b1);
        step(MODE_SHR, 4'b0000, 8'h00, 1'b1);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
